// File: rtl/seg_scan_decoder.sv
// ============================================================================
//  Module   : seg_scan_decoder
//  Purpose  : Recovers a HH:MM:SS time from a multiplexed 7-segment scan bus.
//             Optional macro SEG_RANGE_CHECK_EN rejects out-of-range digits.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_scan_decoder #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] scan_select,
    input  logic [6:0] seg7,
    output logic [1:0] hour_h,
    output logic [3:0] hour_l,
    output logic [2:0] min_h,
    output logic [3:0] min_l,
    output logic [2:0] sec_h,
    output logic [3:0] sec_l,
    output logic       frame_valid,
    output logic [5:0] digit_seen,
    output logic       seg_err
);

    localparam logic [7:0] C_CNT_LAST = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    state_t     r_state;
    logic [5:0] r_sel;
    logic [6:0] r_seg;
    logic [7:0] r_cnt;
    logic [3:0] r_shadow [6];
    logic [5:0] r_seen;
    logic [19:0] r_frame;
    logic       r_frame_valid;
    logic       r_seg_err;

    logic [5:0] w_sel_n;
    logic       w_sel_valid;
    logic       w_changed;
    logic       w_capture_edge;
    logic [3:0] w_digit;
    logic       w_legal;
    logic       w_blank;
    logic [2:0] w_idx;
    logic       w_range_err;
    logic       w_capture;
    logic       w_err_set;
    logic       w_frame_done;
    logic [3:0] w_shadow_next [6];

    assign w_sel_n        = ~scan_select;
    assign w_sel_valid    = (w_sel_n != 6'd0) && ((w_sel_n & (w_sel_n - 6'd1)) == 6'd0);
    assign w_changed      = (scan_select != r_sel) || (seg7 != r_seg);
    assign w_capture_edge = (r_state == ST_SETTLE) && !w_changed && (r_cnt == C_CNT_LAST);

    always_comb begin
        w_digit = 4'd0;
        w_legal = 1'b1;
        w_blank = 1'b0;
        case (r_seg)
            7'b1111110: w_digit = 4'd0;
            7'b0110000: w_digit = 4'd1;
            7'b1101101: w_digit = 4'd2;
            7'b1111001: w_digit = 4'd3;
            7'b0110011: w_digit = 4'd4;
            7'b1011011: w_digit = 4'd5;
            7'b1011111: w_digit = 4'd6;
            7'b1110000: w_digit = 4'd7;
            7'b1111111: w_digit = 4'd8;
            7'b1111011: w_digit = 4'd9;
            7'b0000000: begin
                w_legal = 1'b0;
                w_blank = 1'b1;
            end
            default:    w_legal = 1'b0;
        endcase
    end

    // Stored select is known one-hot (active-low) whenever a capture can occur.
    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (!r_sel[i]) w_idx = 3'(i);
        end
    end

`ifdef SEG_RANGE_CHECK_EN
    always_comb begin
        w_range_err = 1'b0;
        if (w_legal) begin
            case (w_idx)
                3'd5:        w_range_err = (w_digit > 4'd2);
                3'd4:        w_range_err = (w_digit > 4'd3) && (r_shadow[5] == 4'd2);
                3'd3, 3'd1:  w_range_err = (w_digit > 4'd5);
                default:     w_range_err = 1'b0;
            endcase
        end
    end
`else
    assign w_range_err = 1'b0;
`endif

    assign w_capture    = w_capture_edge && w_legal && !w_range_err;
    assign w_err_set    = w_capture_edge && ((!w_legal && !w_blank) || w_range_err);
    assign w_frame_done = (r_seen == 6'h3F);

    // Capture is folded in before a frame copy so a same-edge capture lands in the frame.
    always_comb begin
        for (int i = 0; i < 6; i++) begin
            w_shadow_next[i] = (w_capture && (w_idx == 3'(i))) ? w_digit : r_shadow[i];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_sel         <= 6'h3F;
            r_seg         <= 7'd0;
            r_cnt         <= 8'd0;
            r_seen        <= 6'd0;
            r_frame       <= 20'd0;
            r_frame_valid <= 1'b0;
            r_seg_err     <= 1'b0;
            for (int i = 0; i < 6; i++) r_shadow[i] <= 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        r_state <= ST_SETTLE;
                        r_sel   <= scan_select;
                        r_seg   <= seg7;
                        r_cnt   <= 8'd0;
                    end
                end
                ST_SETTLE: begin
                    if (w_changed) begin
                        r_state <= w_sel_valid ? ST_SETTLE : ST_IDLE;
                        r_sel   <= scan_select;
                        r_seg   <= seg7;
                        r_cnt   <= 8'd0;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_state <= ST_HELD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_HELD: begin
                    if (scan_select != r_sel) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            for (int i = 0; i < 6; i++) r_shadow[i] <= w_shadow_next[i];

            if (w_err_set) r_seg_err <= 1'b1;

            r_frame_valid <= w_frame_done;
            if (w_frame_done) begin
                r_seen  <= 6'd0;
                r_frame <= {w_shadow_next[5][1:0], w_shadow_next[4],
                            w_shadow_next[3][2:0], w_shadow_next[2],
                            w_shadow_next[1][2:0], w_shadow_next[0]};
            end else if (w_capture) begin
                r_seen <= r_seen | (6'd1 << w_idx);
            end
        end
    end

    assign {hour_h, hour_l, min_h, min_l, sec_h, sec_l} = r_frame;
    assign frame_valid = r_frame_valid;
    assign digit_seen  = r_seen;
    assign seg_err     = r_seg_err;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
// ============================================================================
//  Module   : tb_seg_scan_decoder
//  Purpose  : Scoreboard bench for seg_scan_decoder with a digit-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_decoder;

    localparam int S = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic [5:0] scan_select;
    logic [6:0] seg7;
    logic [1:0] hour_h;
    logic [3:0] hour_l;
    logic [2:0] min_h;
    logic [3:0] min_l;
    logic [2:0] sec_h;
    logic [3:0] sec_l;
    logic       frame_valid;
    logic [5:0] digit_seen;
    logic       seg_err;

    seg_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .resetn(resetn), .scan_select(scan_select), .seg7(seg7),
        .hour_h(hour_h), .hour_l(hour_l), .min_h(min_h), .min_l(min_l),
        .sec_h(sec_h), .sec_l(sec_l), .frame_valid(frame_valid),
        .digit_seen(digit_seen), .seg_err(seg_err)
    );

    always #5 clk = ~clk;

    logic [6:0]  pats [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};
    int          checks = 0;
    int          failures = 0;
    int          n_frames = 0;
    logic [19:0] exp_q [$];
    logic [3:0]  m_sh [6];
    logic [5:0]  m_seen;
    logic        m_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Model: one stable slot = one capture attempt of the shown digit.
    task automatic model_apply(input int idx, input logic [6:0] pat);
        int  d;
        logic bad;
        d = -1;
        bad = 1'b0;
        if (pat == 7'd0) return;
        for (int k = 0; k < 10; k++) if (pats[k] == pat) d = k;
        if (d < 0) begin
            m_err = 1'b1;
            return;
        end
`ifdef SEG_RANGE_CHECK_EN
        if (idx == 5 && d > 2) bad = 1'b1;
        if ((idx == 3 || idx == 1) && d > 5) bad = 1'b1;
        if (idx == 4 && d > 3 && m_sh[5] == 4'd2) bad = 1'b1;
`endif
        if (bad) begin
            m_err = 1'b1;
            return;
        end
        m_sh[idx] = 4'(d);
        m_seen[idx] = 1'b1;
        if (m_seen == 6'h3F) begin
            exp_q.push_back({m_sh[5][1:0], m_sh[4], m_sh[3][2:0], m_sh[2], m_sh[1][2:0], m_sh[0]});
            m_seen = 6'd0;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_sh[i] = 4'd0;
        m_seen = 6'd0;
        m_err  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (resetn === 1'b1 && frame_valid === 1'b1) begin
            n_frames++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame actual=pulse required=none @%0t", $time);
            end else begin
                check("frame", {hour_h, hour_l, min_h, min_l, sec_h, sec_l}, exp_q.pop_front());
                check("seen_cleared", digit_seen, 6'd0);
            end
        end
    end

    task automatic slot(input int idx, input logic [6:0] pat, input int n);
        logic [5:0] sel;
        sel = 6'd1 << idx;
        scan_select = ~sel;
        seg7 = pat;
        model_apply(idx, pat);
        repeat (n) @(negedge clk);
        scan_select = 6'h3F;
        seg7 = 7'd0;
        repeat (2) @(negedge clk);
        check("digit_seen", digit_seen, m_seen);
        check("seg_err", seg_err, m_err);
    endtask

    task automatic scan_frame(input int hh, input int hl, input int mh, input int ml,
                              input int sh, input int sl, input int n);
        slot(5, pats[hh], n);
        slot(4, pats[hl], n);
        slot(3, pats[mh], n);
        slot(2, pats[ml], n);
        slot(1, pats[sh], n);
        slot(0, pats[sl], n);
    endtask

    task automatic do_reset();
        check("pending_frames", exp_q.size(), 0);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("rst_time", {hour_h, hour_l, min_h, min_l, sec_h, sec_l}, 20'd0);
        check("rst_flags", {frame_valid, seg_err, digit_seen}, 8'd0);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int f0;
        int idx;
        int d;
        resetn = 1'b0;
        scan_select = 6'h3F;
        seg7 = 7'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_time", {hour_h, hour_l, min_h, min_l, sec_h, sec_l}, 20'd0);
        check("reset_flags", {frame_valid, seg_err, digit_seen}, 8'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Long-slot scan of 23:59:47
        f0 = n_frames;
        scan_frame(2, 3, 5, 9, 4, 7, 1024);
        check("one_frame_pulse", n_frames - f0, 1);
        check("time_235947", {hour_h, hour_l, min_h, min_l, sec_h, sec_l},
              {2'd2, 4'd3, 3'd5, 4'd9, 3'd4, 4'd7});

        // Segments toggling faster than the settle window never capture
        scan_select = 6'b011111;
        for (int k = 0; k < 16; k++) begin
            seg7 = k[0] ? pats[1] : pats[2];
            repeat (4) @(negedge clk);
        end
        scan_select = 6'h3F;
        seg7 = 7'd0;
        repeat (2) @(negedge clk);
        check("unstable_no_capture", digit_seen, m_seen);

        // Blank slot is ignored; frame finishes only after a repeat
        f0 = n_frames;
        slot(5, pats[1], 24);
        slot(4, pats[2], 24);
        slot(3, pats[3], 24);
        slot(2, 7'd0, 24);
        slot(1, pats[4], 24);
        slot(0, pats[5], 24);
        check("blank_no_frame", n_frames - f0, 0);
        slot(2, pats[6], 24);
        check("blank_repeat_frame", n_frames - f0, 1);

        // Reset after three digits discards the partial frame
        slot(5, pats[0], 24);
        slot(4, pats[8], 24);
        slot(3, pats[4], 24);
        do_reset();
        f0 = n_frames;
        scan_frame(1, 9, 3, 0, 5, 2, 24);
        check("post_reset_frame", n_frames - f0, 1);

        // min_h = 7: rejected with range checking, truncated into the frame otherwise
        scan_frame(1, 2, 7, 3, 4, 5, 24);
        scan_frame(0, 6, 2, 8, 1, 9, 24);

        // Randomised slots
        for (int k = 0; k < 200; k++) begin
            idx = $urandom_range(0, 5);
            d = $urandom_range(0, 10);
            slot(idx, (d == 10) ? 7'd0 : pats[d], $urandom_range(S + 3, S + 20));
        end

        // Illegal pattern: sticky until reset
        slot(4, 7'b1010101, 24);
        check("seg_err_set", seg_err, 1'b1);
        scan_frame(1, 1, 1, 1, 1, 1, 24);
        check("seg_err_sticky", seg_err, 1'b1);
        do_reset();
        check("seg_err_cleared", seg_err, 1'b0);

        repeat (4) @(negedge clk);
        check("final_pending", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: consecutive clocks a select/segment pair must hold before capture (range 2..255).
REQ-002 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-003 SHALL have port resetn, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port scan_select, input, 6, active-low one-hot digit select; bit5 = hour_h, then hour_l, min_h, min_l, sec_h, bit0 = sec_l.
REQ-005 SHALL have port seg7, input, 7, active-high segments {a,b,c,d,e,f,g}.
REQ-006 SHALL have ports hour_h (2), hour_l (4), min_h (3), min_l (4), sec_h (3), sec_l (4), all outputs, holding the last completed frame.
REQ-007 SHALL have port frame_valid, output, 1, one-cycle pulse when the time outputs update.
REQ-008 SHALL have port digit_seen, output, 6, per-digit capture flags for the frame in progress, same bit order as scan_select.
REQ-009 SHALL have port seg_err, output, 1, sticky flag for an illegal segment pattern.

Function
REQ-010 SHALL treat scan_select as valid only when exactly one bit is 0; any other value is idle.
REQ-011 SHALL use FSM states IDLE, SETTLE and HELD.
REQ-012 IDLE -> SETTLE on a valid select; the select and seg7 values are stored and the stability counter is cleared.
REQ-013 In SETTLE, any change of scan_select or seg7 SHALL restart SETTLE with the new values; an invalid select returns to IDLE.
REQ-014 SETTLE -> HELD when the counter reaches STABLE_CYCLES-1 with inputs unchanged; capture occurs on that transition edge.
REQ-015 HELD -> IDLE when scan_select changes; one select slot yields at most one capture.
REQ-016 Capture decode: 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9.
REQ-017 Pattern 0000000 (blank) SHALL be ignored: no capture, no error.
REQ-018 Any other pattern SHALL set seg_err and SHALL NOT capture.
REQ-019 A decoded digit SHALL be written to a shadow register and its digit_seen bit set; a repeat capture overwrites the shadow value.
REQ-020 When all six digit_seen bits are 1 after a capture, the next edge SHALL copy all shadows to the outputs at once, pulse frame_valid, and clear digit_seen.
REQ-021 Narrow fields SHALL take the low bits of the decoded value (hour_h takes [1:0]; min_h and sec_h take [2:0]).
REQ-022 A capture and a frame completion on the same edge SHALL first apply the capture, then copy that value into the frame.

Reset
REQ-023 On resetn low, immediately: FSM = IDLE, counter = 0, shadows and all time outputs = 0, digit_seen = 000000, frame_valid = 0, seg_err = 0.
REQ-024 Reset mid-frame SHALL discard partial captures; after release, capture restarts from an empty frame.
REQ-025 seg_err SHALL clear only on reset.

Configuration
REQ-026 Macro SEG_RANGE_CHECK_EN SHALL gate range checking.
REQ-027 With SEG_RANGE_CHECK_EN defined, a captured digit out of range SHALL set seg_err and SHALL NOT be captured: hour_h>2, min_h or sec_h>5, or hour_l>3 when the hour_h shadow is 2.
REQ-028 Without SEG_RANGE_CHECK_EN, only REQ-018 sets seg_err, and values truncate per REQ-021.

Verification
REQ-029 Scan 2,3,5,9,4,7 (hour_h..sec_l), each slot 1024 clocks -> hour 23, min 59, sec 47; frame_valid pulses exactly once; digit_seen returns to 000000.
REQ-030 seg7 toggles every 4 clocks inside one slot with STABLE_CYCLES=16 -> no capture; digit_seen unchanged.
REQ-031 Slot hour_l with seg7=1010101 -> seg_err=1 and stays 1 through later valid frames until resetn pulses low.
REQ-032 Slot with seg7=0000000 -> no capture, seg_err=0; frame completes only after a valid repeat of that slot.
REQ-033 With SEG_RANGE_CHECK_EN, min_h slot shows 7 -> seg_err=1 and min_h not captured; without the macro -> min_h=7 after the frame.
REQ-034 resetn low after 3 of 6 digits -> all outputs 0 asynchronously; a full scan afterwards yields one frame_valid with the new values.
